// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving an 8-bit ALU and a single-port synchronous RAM.
// Optional `zero` flag output is built when CU_ZERO_FLAG_EN is defined.
module cpu_control_unit #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       busy,
    output logic       halted,
    output logic [7:0] pc,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       alu_start,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_opcode,
    input  logic [7:0] alu_result
`ifdef CU_ZERO_FLAG_EN
    ,
    output logic       zero
`endif
);

    // state    | meaning
    // IDLE     | waiting for run
    // FETCH    | pc on mem_addr, RAM read in flight
    // DECODE   | latch IR, pc++
    // IMM_ADDR | pc on mem_addr for immediate byte, pc++
    // IMM_DATA | latch immediate; LDI writes Rd
    // STORE    | one-cycle RAM write of Rd to immediate address
    // EXEC     | alu_start held for ALU_LATENCY cycles
    // WB       | Rd <= alu_result
    // HALTED   | terminal until rst
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IMM_ADDR, S_IMM_DATA,
        S_STORE, S_EXEC, S_WB, S_HALTED
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_ST   = 2'b10;
    localparam logic [1:0] LAT_INIT = 2'(ALU_LATENCY - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  imm_q, imm_d;
    logic [7:0]  regs_q [4];
    logic [7:0]  regs_d [4];
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
`ifdef CU_ZERO_FLAG_EN
    logic        zero_q, zero_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            imm_q     <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            lat_cnt_q <= '0;
`ifdef CU_ZERO_FLAG_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            regs_q    <= regs_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            lat_cnt_q <= lat_cnt_d;
`ifdef CU_ZERO_FLAG_EN
            zero_q    <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        regs_d    = regs_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        lat_cnt_d = lat_cnt_q;
`ifdef CU_ZERO_FLAG_EN
        zero_d    = zero_q;
`endif
        case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                ir_d = mem_rdata;
                pc_d = pc_q + 8'd1;
                // Operands come straight from RAM data so they are registered by the first EXEC cycle
                case (mem_rdata[7:6])
                    CLS_ALU: begin
                        alu_a_d   = regs_q[mem_rdata[3:2]];
                        alu_b_d   = regs_q[mem_rdata[1:0]];
                        alu_op_d  = mem_rdata[5:4];
                        lat_cnt_d = LAT_INIT;
                        state_d   = S_EXEC;
                    end
                    CLS_LDI, CLS_ST: state_d = S_IMM_ADDR;
                    default:         state_d = S_HALTED;
                endcase
            end
            S_IMM_ADDR: begin
                pc_d    = pc_q + 8'd1;
                state_d = S_IMM_DATA;
            end
            S_IMM_DATA: begin
                imm_d = mem_rdata;
                if (ir_q[7:6] == CLS_LDI) begin
                    regs_d[ir_q[3:2]] = mem_rdata;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_STORE:    state_d = S_FETCH;
            S_EXEC: begin
                // Re-assert operands from the latched IR; values are identical to those loaded in DECODE
                alu_a_d  = regs_q[ir_q[3:2]];
                alu_b_d  = regs_q[ir_q[1:0]];
                alu_op_d = ir_q[5:4];
                if (lat_cnt_q == 2'd0) state_d = S_WB;
                else                   lat_cnt_d = lat_cnt_q - 2'd1;
            end
            S_WB: begin
                regs_d[ir_q[3:2]] = alu_result;
`ifdef CU_ZERO_FLAG_EN
                zero_d = (alu_result == 8'd0);
`endif
                state_d = S_FETCH;
            end
            S_HALTED:   state_d = S_HALTED;
            default:    state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);
    assign pc         = pc_q;
    assign mem_addr   = (state_q == S_STORE) ? imm_q : pc_q;
    // Gated by rst so a reset landing in STORE suppresses the write at that same edge
    assign mem_we     = (state_q == S_STORE) && !rst;
    assign mem_wdata  = (state_q == S_STORE) ? regs_q[ir_q[3:2]] : 8'd0;
    assign alu_start  = (state_q == S_EXEC);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
`ifdef CU_ZERO_FLAG_EN
    assign zero       = zero_q;
`endif

endmodule
